// File: rtl/ctech_clk_div_pkg.sv
// Shared types and helpers for the clock-divider sequencer.
package ctech_clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int unsigned MIN_RATIO = 2;

    // High-phase length of one output period: ceil(r/2).
    function automatic int unsigned hi_len(input int unsigned r);
        return (r + 1) / 2;
    endfunction

endpackage

// File: rtl/ctech_clk_div_cnt.sv
// Period counter for the clock divider: counts 0..ratio-1, flags the wrap and
// produces the next-cycle duty value for the clock flop d pin.
module ctech_clk_div_cnt
    import ctech_clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             active_nxt,
    input  logic [CNT_W-1:0] ratio,
    input  logic [CNT_W-1:0] ratio_nxt,
    output logic             wrap_c,
    output logic [CNT_W-1:0] cnt_nxt_c,
    output logic             duty_nxt_c
);

    logic [CNT_W-1:0] cnt;

    // Duty is judged against the ratio that will be in force next cycle, so a
    // ratio load at the wrap shapes the very first cycle of the new period.
    always_comb begin
        wrap_c     = (cnt == ratio - CNT_W'(1));
        cnt_nxt_c  = (!run || wrap_c) ? '0 : cnt + CNT_W'(1);
        duty_nxt_c = active_nxt && (cnt_nxt_c < CNT_W'(hi_len(32'(ratio_nxt))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/ctech_lib_clk_div_seq.sv
// Divide-by-N sequencer for the clock-network flop (d/rstb) with glitch-free ratio
// handshake. Optional period counter output under CTECH_CLK_DIV_PERIOD_CNT_EN.
module ctech_lib_clk_div_seq
    import ctech_clk_div_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DEF_RATIO = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic             ratio_req,
    input  logic [CNT_W-1:0] ratio_val,
    output logic             ratio_ack,
    output logic             ff_d,
    output logic             ff_rstb,
    output logic             period_start,
    output logic             busy
`ifdef CTECH_CLK_DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] ratio;
    logic [CNT_W-1:0] ratio_nxt;
    logic [CNT_W-1:0] ratio_clamped;
    logic             ack_q;
    logic             req_ok;
    logic             load;
    logic             wrap;
    logic [CNT_W-1:0] cnt_nxt;
    logic             duty_nxt;
    logic             active_nxt;
    logic             busy_nxt;
    logic             ps_nxt;

    // A request still high during the ack cycle or the one after is the old one.
    assign req_ok        = ratio_req && !ratio_ack && !ack_q;
    assign ratio_clamped = (ratio_val < CNT_W'(MIN_RATIO)) ? CNT_W'(MIN_RATIO) : ratio_val;

    ctech_clk_div_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .run        (state != IDLE),
        .active_nxt (active_nxt),
        .ratio      (ratio),
        .ratio_nxt  (ratio_nxt),
        .wrap_c     (wrap),
        .cnt_nxt_c  (cnt_nxt),
        .duty_nxt_c (duty_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Transitions; a stop or reload that coincides with the wrap takes effect at once
    // so no extra old-ratio period is emitted.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                load = req_ok;
                if (div_en) state_nxt = RUN;
            end
            RUN: begin
                if (!div_en) begin
                    state_nxt = wrap ? IDLE : STOP;
                end else if (req_ok) begin
                    if (wrap) load = 1'b1;
                    else      state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (wrap) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            STOP: begin
                if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ratio_nxt  = load ? ratio_clamped : ratio;
        active_nxt = (state_nxt != IDLE);
        busy_nxt   = (state_nxt == RUN) || (state_nxt == DRAIN);
        ps_nxt     = active_nxt && (cnt_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ratio        <= CNT_W'(DEF_RATIO);
            ratio_ack    <= 1'b0;
            ack_q        <= 1'b0;
            ff_d         <= 1'b0;
            ff_rstb      <= 1'b0;
            period_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ratio        <= ratio_nxt;
            ratio_ack    <= load;
            ack_q        <= ratio_ack;
            ff_d         <= duty_nxt;
            ff_rstb      <= 1'b1;
            period_start <= ps_nxt;
            busy         <= busy_nxt;
        end
    end

`ifdef CTECH_CLK_DIV_PERIOD_CNT_EN
    // Saturating count of output periods since the last reset or ratio change.
    always_ff @(posedge clk) begin
        if (rst || ratio_ack) begin
            period_cnt <= '0;
        end else if (period_start && (period_cnt != 16'hFFFF)) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ctech_lib_clk_div_seq.md
Name: ctech_lib_clk_div_seq

Overview:
- Sequencer that drives the d and rstb pins of the clock-network flop cell (clkout = registered d, active-low reset).
- Generates the per-cycle toggle pattern so that the flop output is a divide-by-N clock.
- Supports glitch-free runtime ratio changes via a req/ack handshake, plus a clean start/stop.
- Sits in the clock-control partition, directly ahead of the clock flop instance.

Parameters:
- CNT_W, 8, width of the ratio and the period counter.
- DEF_RATIO, 2, divide ratio loaded at reset; must be >= 2.

Ports:
- clk  in  1  source clock; the same clock drives the downstream clock flop.
- rst  in  1  synchronous reset, active-high.
- div_en  in  1  level; 1 = run the divider, 0 = park the clock low.
- ratio_req  in  1  level request to load ratio_val; held until ratio_ack.
- ratio_val  in  CNT_W  new divide ratio; must be stable while ratio_req=1.
- ratio_ack  out  1  one-cycle pulse when the new ratio has taken effect.
- ff_d  out  1  d input of the clock flop.
- ff_rstb  out  1  active-low reset for the clock flop.
- period_start  out  1  one-cycle pulse on the first cycle of each output period (cnt==0 in RUN).
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset values (rst=1, synchronous):
  - state=IDLE, cnt=0, ratio=DEF_RATIO.
  - ff_d=0, ff_rstb=0, ratio_ack=0, period_start=0, busy=0.
- ff_rstb is registered: 0 while in reset, 1 from the first cycle after rst deasserts.
- Ratio clamp: a ratio_val below 2 loads as 2. Ratio is unsigned, CNT_W bits, maximum 2^CNT_W-1.
- Counter: in RUN, cnt counts 0..ratio-1 and wraps to 0.
- Duty cycle: ff_d = 1 when cnt < ceil(ratio/2), else 0.
  - Odd ratios give a high phase one cycle longer than the low phase.
  - clkout lags ff_d by one cycle through the flop.
- FSM states: IDLE, RUN, DRAIN, STOP.
  - IDLE: ff_d=0, cnt=0.
    - div_en=1 -> RUN, starting at cnt=0 on the next cycle.
    - If ratio_req=1, the ratio loads immediately and ratio_ack pulses the next cycle (no period is in flight).
  - RUN:
    - ratio_req=1 -> DRAIN.
    - div_en=0 -> STOP.
    - If both occur in the same cycle, STOP wins. The pending request is serviced once IDLE is reached.
  - DRAIN: keep counting with the old ratio. At cnt==ratio-1, load the new ratio, set cnt=0, pulse ratio_ack, -> RUN.
    - No runt or stretched period is allowed.
  - STOP: complete the current period. At cnt==ratio-1 -> IDLE, with ff_d=0 from that point.
  - div_en returning to 1 while in STOP does not abort the stop: reach IDLE, then restart.
- Handshake:
  - ratio_ack is exactly one cycle.
  - The requester must drop ratio_req on the cycle after ack.
  - If ratio_req is still 1 on the second cycle after ack, it is treated as a new request.
- Reset asserted mid-period: outputs return to their reset values on the next edge. A truncated clkout period is permitted only under reset.
- Boundary case, ratio==2: ff_d alternates 1,0. period_start fires every 2 cycles.

Optional Feature:
- Macro: CTECH_CLK_DIV_PERIOD_CNT_EN.
- When defined:
  - Adds output period_cnt[15:0], a count of completed output periods.
  - Increments on each period_start, saturates at 0xFFFF, clears on rst or on ratio_ack.
- When undefined: the port is absent and no counter logic is generated.

Decomposition:
- Shared package ctech_clk_div_pkg holds:
  - the state enum typedef (IDLE/RUN/DRAIN/STOP);
  - the localparam MIN_RATIO=2;
  - the function computing the high-phase length ceil(r/2).
- One natural sub-module: ctech_clk_div_cnt, holding the period counter, wrap detect and duty compare.
- The top level holds the FSM, handshake and optional counter.

Test Plan:
- Reset, then div_en=1 with DEF_RATIO=2 -> ff_rstb=1 one cycle after rst falls; ff_d = 1,0,1,0; period_start every 2 cycles.
- Ratio 5, running -> ff_d high 3 cycles, low 2 cycles; period_start every 5 cycles.
- Request ratio 4 while running at ratio 6 with cnt=1 -> ratio_ack asserts at the wrap (cnt 5->0); the next period is 2 high / 2 low; no shortened period.
- div_en=0 and ratio_req=1 in the same RUN cycle -> current period completes, state=IDLE with ff_d=0, then the ratio loads and ratio_ack pulses one cycle later.
- ratio_val=1 requested -> ratio loads as 2 and ratio_ack pulses. Separately, assert rst at cnt=3 of ratio 8 -> all outputs at reset values the next cycle.
- With CTECH_CLK_DIV_PERIOD_CNT_EN, ratio 2, 10 periods -> period_cnt=10; after a ratio change -> 0. Forcing 0xFFFF plus one period stays at 0xFFFF.
